// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC step, NOP encoding and the
// prefetch buffer entry layout.
package cpu_pkg;
    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 16'd2;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Shift-style prefetch FIFO: entry 0 is always the head, so the head output is
// a plain register and keeps its last contents once the buffer runs empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wr_entry,
    output fetch_entry_t       head,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     ent [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] wr_idx;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & head_valid;
    // With a pop the survivors shift down one slot, so the free slot moves too.
    assign wr_idx  = do_pop ? count - 1'b1 : count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && wr_idx == CNT_W'(i)) begin
                    ent[i] <= wr_entry;
                end else if (do_pop && CNT_W'(i + 1) < count) begin
                    ent[i] <= ent[(i + 1) % DEPTH];
                end
            end
        end
    end

    assign head       = ent[0];
    assign head_valid = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, arbitrates push against redirect and
// presents buffered {pc, instr} words to decode through a valid/ready handshake.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus2,
    input  logic               id_ready
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    logic [ADDR_W-1:0] pc;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;
    logic              head_valid;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              push;

    assign pop  = head_valid & id_ready;
    // A full buffer may still accept a word when the head leaves this cycle.
    assign push = fetch_en & ~redirect_valid & ((count < FULL) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    assign wr_entry.pc    = pc;
    assign wr_entry.instr = imem_instr;

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .wr_entry   (wr_entry),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign imem_pc     = pc;
    assign if_valid    = head_valid;
    assign if_instr    = head_valid ? head.instr : NOP_INSTR;
    assign if_pc       = head.pc;
    assign if_pc_plus2 = head.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a queue-based scoreboard of
// fetched {pc, instr} entries for the depth-2 instance.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        id_ready = 1'b0;

    logic [15:0] imem_pc, imem_instr, if_instr, if_pc, if_pc_plus2;
    logic        if_valid;
    logic [15:0] b_imem_pc, b_imem_instr, b_if_instr, b_if_pc, b_if_pc_plus2;
    logic        b_if_valid;

    int checks = 0;
    int errors = 0;

    fetch_entry_t q[$];
    logic [15:0]  m_pc = 16'h0000;
    logic [15:0]  m_last = 16'h0000;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        if (a == 16'h0100) return 16'h0000;
        return 16'h7000 + {a[9:0], 6'b0};
    endfunction

    assign imem_instr   = mem(imem_pc);
    assign b_imem_instr = mem(b_imem_pc);

    fetch_unit #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_pc(imem_pc),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus2(if_pc_plus2), .id_ready(id_ready)
    );

    fetch_unit #(.RESET_PC(16'hFFFC), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_pc(b_imem_pc),
        .imem_instr(b_imem_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(b_if_valid), .if_instr(b_if_instr),
        .if_pc(b_if_pc), .if_pc_plus2(b_if_pc_plus2), .id_ready(id_ready)
    );

    // One clock edge; the scoreboard for the depth-2 instance advances with it.
    task automatic tick();
        bit mpop, mpush;
        mpop  = (q.size() != 0) && id_ready;
        mpush = fetch_en && !redirect_valid && ((q.size() < 2) || mpop);
        @(posedge clk);
        if (rst_n) begin
            if (q.size() != 0) m_last = q[0].pc;
            if (redirect_valid) begin
                q.delete();
                m_pc = {redirect_pc[15:1], 1'b0};
            end else begin
                if (mpop) void'(q.pop_front());
                if (mpush) begin
                    q.push_back('{pc: m_pc, instr: mem(m_pc)});
                    m_pc = m_pc + 16'd2;
                end
            end
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = 16'h0000;
        m_last = 16'h0000;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        fetch_en = 1'b1;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        checks++; if (if_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", if_instr); end
        checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", if_pc); end
        checks++; if (if_pc_plus2 !== 16'h0002) begin errors++; $display("FAIL reset_pc_plus2: got %h expected 0002", if_pc_plus2); end
        checks++; if (imem_pc !== 16'h0000) begin errors++; $display("FAIL reset_imem_pc: got %h expected 0000", imem_pc); end
        checks++; if (b_imem_pc !== 16'hFFFC) begin errors++; $display("FAIL reset_imem_pc_b: got %h expected fffc", b_imem_pc); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_pc = 16'(2 * i);
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, if_valid); end
            checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, if_pc, exp_pc); end
            checks++; if (q.size() == 0 || if_instr !== q[0].instr) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, if_instr, mem(exp_pc)); end
            checks++; if (imem_pc !== exp_pc + 16'd2) begin errors++; $display("FAIL stream_imem_pc[%0d]: got %h expected %h", i, imem_pc, exp_pc + 16'd2); end
        end
        checks++; if (if_instr !== 16'h7200) begin errors++; $display("FAIL stream_instr_at_8: got %h expected 7200", if_instr); end
    endtask

    task automatic test_stall();
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'h0002; exp_seq[1] = 16'h0004; exp_seq[2] = 16'h0006;
        reset_dut();
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (imem_pc !== 16'h0004) begin errors++; $display("FAIL stall_imem_pc: got %h expected 0004", imem_pc); end
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin errors++; $display("FAIL stall_head: got %b/%h expected 1/0000", if_valid, if_pc); end
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_valid !== 1'b1 || if_pc !== exp_seq[i]) begin errors++; $display("FAIL stall_drain[%0d]: got %b/%h expected 1/%h", i, if_valid, if_pc, exp_seq[i]); end
        end
    endtask

    task automatic test_redirect();
        reset_dut();
        id_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h001C;
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b expected 0", if_valid); end
        checks++; if (imem_pc !== 16'h001C) begin errors++; $display("FAIL redir_imem_pc: got %h expected 001c", imem_pc); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h001C) begin errors++; $display("FAIL redir_target: got %b/%h expected 1/001c", if_valid, if_pc); end
        checks++; if (if_instr !== mem(16'h001C)) begin errors++; $display("FAIL redir_instr: got %h expected %h", if_instr, mem(16'h001C)); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect_pc = 16'h0081;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_pc !== 16'h0080 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_b2b: got %h/%b expected 0080/0", imem_pc, if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0080) begin errors++; $display("FAIL redir_b2b_head: got %b/%h expected 1/0080", if_valid, if_pc); end
    endtask

    task automatic test_fetch_en();
        reset_dut();
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0025;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_pc !== 16'h0024) begin errors++; $display("FAIL odd_redirect: got %h expected 0024", imem_pc); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0024) begin errors++; $display("FAIL fe_one_entry: got %b/%h expected 1/0024", if_valid, if_pc); end
        fetch_en = 1'b0;
        id_ready = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000) begin errors++; $display("FAIL fe_drain: got %b/%h expected 0/0000", if_valid, if_instr); end
        checks++; if (if_pc !== 16'h0024) begin errors++; $display("FAIL fe_pc_hold: got %h expected 0024", if_pc); end
        tick();
        checks++; if (imem_pc !== 16'h0026 || if_valid !== 1'b0) begin errors++; $display("FAIL fe_pc_frozen: got %h/%b expected 0026/0", imem_pc, if_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (imem_pc !== 16'h0100 || if_valid !== 1'b0) begin errors++; $display("FAIL fe_redirect: got %h/%b expected 0100/0", imem_pc, if_valid); end
        fetch_en = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== 16'h0000) begin errors++; $display("FAIL nop_word: got %b/%h/%h expected 1/0100/0000", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_wrap();
        logic [15:0] wrap_pc [3];
        wrap_pc[0] = 16'hFFFC; wrap_pc[1] = 16'hFFFE; wrap_pc[2] = 16'h0000;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b_if_valid !== 1'b1 || b_if_pc !== wrap_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %b/%h expected 1/%h", i, b_if_valid, b_if_pc, wrap_pc[i]); end
            checks++; if (b_if_pc_plus2 !== wrap_pc[i] + 16'd2) begin errors++; $display("FAIL wrap_plus2[%0d]: got %h expected %h", i, b_if_pc_plus2, wrap_pc[i] + 16'd2); end
            checks++; if (b_if_instr !== mem(wrap_pc[i])) begin errors++; $display("FAIL wrap_instr[%0d]: got %h expected %h", i, b_if_instr, mem(wrap_pc[i])); end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        id_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (if_valid !== 1'b1 || imem_pc !== 16'h0004) begin errors++; $display("FAIL areset_pre: got %b/%h expected 1/0004", if_valid, imem_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000) begin errors++; $display("FAIL areset_valid: got %b/%h expected 0/0000", if_valid, if_instr); end
        checks++; if (imem_pc !== 16'h0000 || if_pc !== 16'h0000) begin errors++; $display("FAIL areset_pc: got %h/%h expected 0000/0000", imem_pc, if_pc); end
        checks++; if (b_imem_pc !== 16'hFFFC) begin errors++; $display("FAIL areset_pc_b: got %h expected fffc", b_imem_pc); end
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic        exp_valid;
        logic [15:0] exp_pc, exp_instr;
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            fetch_en       = ($urandom_range(0, 7) != 0);
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 16'($urandom);
            tick();
            exp_valid = (q.size() != 0);
            exp_pc    = exp_valid ? q[0].pc : m_last;
            exp_instr = exp_valid ? q[0].instr : 16'h0000;
            checks++;
            if (if_valid !== exp_valid || if_pc !== exp_pc || if_instr !== exp_instr ||
                if_pc_plus2 !== exp_pc + 16'd2 || imem_pc !== m_pc) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b pc=%h ins=%h p2=%h imem=%h expected v=%b pc=%h ins=%h p2=%h imem=%h",
                         i, if_valid, if_pc, if_instr, if_pc_plus2, imem_pc,
                         exp_valid, exp_pc, exp_instr, exp_pc + 16'd2, m_pc);
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fetch_en();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit single-issue CPU. It owns the program counter and drives the combinational instruction memory's address. It captures the returned instruction word with its PC into a small prefetch buffer and presents it to decode through a valid/ready handshake. It also handles control-flow redirects from execute by flushing the buffer and reloading the PC.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- BUF_DEPTH, 2, prefetch buffer entries; legal values 2 or 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- fetch_en  in  1  when 0, no new fetches are pushed; buffered entries still drain.
- imem_pc  out  16  address to instruction memory; equals the internal PC register.
- imem_instr  in  16  instruction word at imem_pc, valid combinationally in the same cycle.
- redirect_valid  in  1  one-cycle pulse from execute: taken branch or jump.
- redirect_pc  in  16  redirect target; bit 0 is ignored (forced to 0).
- if_valid  out  1  head buffer entry is valid.
- if_instr  out  16  instruction at buffer head.
- if_pc  out  16  PC of if_instr.
- if_pc_plus2  out  16  if_pc + 2, modulo 2^16, for link and branch-offset use.
- id_ready  in  1  decode accepts the head entry this cycle.

## Operation
- State: the PC register; a FIFO of {pc, instr} entries, BUF_DEPTH deep; an occupancy count.
- pop = if_valid & id_ready.
- push = fetch_en & !redirect_valid & (count < BUF_DEPTH | pop).
- On push:
  - Enqueue {imem_pc, imem_instr}.
  - PC <= PC + 2, modulo 2^16. 16'hFFFE wraps to 16'h0000.
- On pop, dequeue the head.
- Push and pop in the same cycle:
  - count is unchanged.
  - Full with pop is legal: the pop frees the slot used by the push.
- Redirect has priority over everything that cycle:
  - All entries are discarded, count <= 0.
  - PC <= {redirect_pc[15:1], 1'b0}.
  - No push, and a concurrent pop is not recorded (decode flushes on its side).
- When fetch_en=0 the PC holds. A redirect is still honoured while fetch_en=0.
- Instruction contents are not interpreted. A NOP (16'h0000) is buffered like any other word.
- if_* outputs come directly from the FIFO head registers, with no combinational path from id_ready.
- When if_valid=0, if_instr is 16'h0000 (NOP) and if_pc holds its last value.

## Timing
- Reset values:
  - PC = RESET_PC, so imem_pc = RESET_PC.
  - count = 0, if_valid = 0, if_instr = 16'h0000.
  - if_pc = 0, if_pc_plus2 = 2.
- Reset mid-operation clears all entries immediately and asynchronously. The first fetch happens on the first rising edge after rst_n rises.
- Fetch-to-decode latency is 1 cycle: a word pushed at edge N is visible on if_* after edge N, provided the buffer was empty.
- With id_ready held at 1 and no redirects, throughput is one instruction per cycle and occupancy stays at 1.
- Redirect sampled at edge N:
  - After N: imem_pc = target, if_valid = 0.
  - After N+1: if_valid = 1, if_pc = target.
  - The redirect penalty is 1 bubble cycle beyond the flush.
- With id_ready = 0, at most BUF_DEPTH pushes occur and then the PC freezes. When id_ready returns, the first pop cycle also pushes.
- Back-to-back redirect pulses: each is honoured, and the last one wins.

## Structure
- Shared package cpu_pkg:
  - INSTR_W = 16, ADDR_W = 16, PC_STEP = 2.
  - NOP_INSTR = 16'h0000.
  - typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo:
  - Parameterised depth, synchronous push/pop/flush, registered head output, count output.
- The PC logic and push/redirect arbitration live in fetch_unit.

## Test plan
- Reset release with fetch_en = 1 and id_ready = 1: after 5 cycles the if_pc sequence is 0, 2, 4, 6, 8, with if_instr matching the memory contents (8 -> 16'h7200); if_valid goes high 1 cycle after reset.
- id_ready = 0 for 6 cycles from PC = 0 (BUF_DEPTH = 2): imem_pc stops at 4 and count = 2. Raising id_ready then yields if_pc 0, 2, 4 with no gap.
- redirect_valid pulse with redirect_pc = 16'h001C while 2 entries are buffered: next cycle if_valid = 0 and imem_pc = 16'h001C; the cycle after, if_pc = 16'h001C. The stale entries never appear on if_*.
- Wrap: RESET_PC = 16'hFFFC gives if_pc sequence FFFC, FFFE, 0000; if_pc_plus2 at FFFE equals 0000.
- Odd redirect_pc = 16'h0025 loads PC = 16'h0024. fetch_en = 0 with 1 entry buffered: that entry drains, then if_valid = 0 and imem_pc holds.
- rst_n asserted mid-stream with 2 entries buffered: if_valid drops immediately, before the clock edge, and imem_pc = RESET_PC.
